// File: rtl/ram_copy_engine.sv
// ram_copy_engine: RAM-port initiator that copies a byte block between two regions
// or fills a region with a constant, then pulses done.
module ram_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              fill,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [7:0]        len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] src_ptr, src_nx, dst_ptr, dst_nx;
    logic [7:0]        cnt, cnt_nx;
    logic              fill_q, fill_nx;
    logic [DATA_W-1:0] data_q, data_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
            fill_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state   <= state_nx;
            src_ptr <= src_nx;
            dst_ptr <= dst_nx;
            cnt     <= cnt_nx;
            fill_q  <= fill_nx;
            data_q  <= data_nx;
        end
    end
    always_comb begin
        state_nx = state;
        src_nx   = src_ptr;
        dst_nx   = dst_ptr;
        cnt_nx   = cnt;
        fill_nx  = fill_q;
        data_nx  = data_q;
        unique case (state)
            IDLE: if (start) begin
                src_nx   = src_addr;
                dst_nx   = dst_addr;
                cnt_nx   = len;
                fill_nx  = fill;
                data_nx  = fill ? fill_val : data_q;
                state_nx = (len == 8'd0) ? DONE : (fill ? WR : RD);
            end
            RD:   state_nx = CAP;
            CAP: begin
                data_nx  = mem_rdata;
                state_nx = WR;
            end
            WR: begin
                dst_nx   = dst_ptr + 1'b1;
                src_nx   = fill_q ? src_ptr : src_ptr + 1'b1;
                cnt_nx   = cnt - 8'd1;
                state_nx = (cnt == 8'd1) ? DONE : (fill_q ? WR : RD);
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // All outputs come straight from registered state, so no input reaches an output combinationally.
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign mem_re    = state == RD;
    assign mem_we    = state == WR;
    assign mem_addr  = (state == RD) ? src_ptr : dst_ptr;
    assign mem_wdata = data_q;
endmodule

// File: tb/tb_ram_copy_engine.sv
// tb_ram_copy_engine: directed checks of copy, wrapping fill, len=0, busy-ignore with overlap,
// and asynchronous reset mid-transfer, with a write scoreboard fed from a RAM model.
module tb_ram_copy_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       fill = 1'b0;
    logic [7:0] src_addr = '0, dst_addr = '0, len = '0, fill_val = '0;
    logic       busy, done, mem_re, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic [7:0] ram [256];
    logic [7:0] mdl [256];
    int total = 0, bad = 0;
    int cyc = 0, t0 = 0;
    int done_cnt = 0, strobes = 0, busy_cyc = 0, overlap = 0;
    int dc, sc, bc;
    typedef struct { logic [7:0] a; logic [7:0] d; int c; } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    always #5 clk = ~clk;

    ram_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fill(fill),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_re && mem_we) overlap++;
            if (done) done_cnt++;
            if (mem_re || mem_we) strobes++;
            if (busy) busy_cyc++;
            if (mem_we) begin
                if (exp_q.size() == 0) chk("wr_unexpected_qsize", exp_q.size(), 1);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", mem_addr, mon_e.a);
                    chk("wr_data", mem_wdata, mon_e.d);
                    chk("wr_cycle", cyc - t0, mon_e.c);
                end
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        ram[a] = v;
        mdl[a] = v;
    endtask

    task automatic push_copy(input logic [7:0] s, input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] sa, da;
            sa = s + 8'(i);
            da = d + 8'(i);
            mdl[da] = mdl[sa];
            exp_q.push_back('{da, mdl[da], 3 + 3 * i});
        end
    endtask

    task automatic push_fill(input logic [7:0] d, input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) begin
            logic [7:0] da;
            da = d + 8'(i);
            mdl[da] = v;
            exp_q.push_back('{da, v, 1 + i});
        end
    endtask

    task automatic issue(input logic f, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] l, input logic [7:0] v);
        @(negedge clk);
        start = 1'b1; fill = f; src_addr = s; dst_addr = d; len = l; fill_val = v;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        fill = 1'($urandom);
        src_addr = 8'($urandom);
        dst_addr = 8'($urandom);
        len = 8'($urandom);
        fill_val = 8'($urandom);
        chk("busy_cycle1", busy, 1);
    endtask

    task automatic wait_done(input string tag, input int exp_rel);
        int n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_cycle"}, cyc - t0, exp_rel);
        @(negedge clk);
        chk({tag, "_done_width"}, done, 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_re"}, mem_re, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) poke(8'(i), 8'(i) ^ 8'h3C);
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // copy of four bytes
        poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
        dc = done_cnt;
        issue(1'b0, 8'h10, 8'h80, 8'd4, 8'h00);
        push_copy(8'h10, 8'h80, 4);
        wait_done("copy", 13);
        chk("copy_done_pulses", done_cnt - dc, 1);
        chk("copy_dst0", ram[8'h80], 8'hA1);
        chk("copy_dst1", ram[8'h81], 8'hB2);
        chk("copy_dst2", ram[8'h82], 8'hC3);
        chk("copy_dst3", ram[8'h83], 8'hD4);
        chk("copy_src0", ram[8'h10], 8'hA1);
        chk("copy_src3", ram[8'h13], 8'hD4);

        // fill wrapping past the top of the address space
        poke(8'h01, 8'h33);
        dc = done_cnt;
        issue(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A);
        push_fill(8'hFE, 3, 8'h5A);
        wait_done("fill", 4);
        chk("fill_done_pulses", done_cnt - dc, 1);
        chk("fill_fe", ram[8'hFE], 8'h5A);
        chk("fill_ff", ram[8'hFF], 8'h5A);
        chk("fill_00", ram[8'h00], 8'h5A);
        chk("fill_01_untouched", ram[8'h01], 8'h33);

        // zero length
        sc = strobes; bc = busy_cyc; dc = done_cnt;
        issue(1'b0, 8'h40, 8'h90, 8'd0, 8'h00);
        wait_done("len0", 1);
        chk("len0_strobes", strobes - sc, 0);
        chk("len0_busy_cycles", busy_cyc - bc, 1);
        chk("len0_done_pulses", done_cnt - dc, 1);

        // overlapping forward copy with an ignored second start
        poke(8'h20, 8'h77); poke(8'h21, 8'h11); poke(8'h22, 8'h22); poke(8'h23, 8'h33);
        poke(8'h50, 8'h99);
        dc = done_cnt;
        issue(1'b0, 8'h20, 8'h21, 8'd3, 8'h00);
        push_copy(8'h20, 8'h21, 3);
        @(negedge clk);
        start = 1'b1; fill = 1'b1; dst_addr = 8'h50; len = 8'd5; fill_val = 8'hEE;
        @(negedge clk);
        start = 1'b0;
        wait_done("ovl", 10);
        chk("ovl_done_pulses", done_cnt - dc, 1);
        chk("ovl_21", ram[8'h21], 8'h77);
        chk("ovl_22", ram[8'h22], 8'h77);
        chk("ovl_23", ram[8'h23], 8'h77);
        chk("ovl_ignored_50", ram[8'h50], 8'h99);

        // asynchronous reset in the middle of a long copy
        for (int i = 0; i < 8; i++) begin
            poke(8'h40 + 8'(i), 8'hC0 + 8'(i));
            poke(8'hA0 + 8'(i), 8'hEE);
        end
        issue(1'b0, 8'h40, 8'hA0, 8'd8, 8'h00);
        push_copy(8'h40, 8'hA0, 1);
        repeat (4) @(negedge clk);
        chk("rst_pre_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1 chk_zero("midrst");
        chk("midrst_qsize", exp_q.size(), 0);
        chk("midrst_byte0", ram[8'hA0], 8'hC0);
        chk("midrst_byte1", ram[8'hA1], 8'hEE);
        @(negedge clk);
        rst_n = 1'b1;
        dc = done_cnt;
        issue(1'b0, 8'h47, 8'hC0, 8'd1, 8'h00);
        push_copy(8'h47, 8'hC0, 1);
        wait_done("post_rst", 4);
        chk("post_rst_done_pulses", done_cnt - dc, 1);
        chk("post_rst_c0", ram[8'hC0], 8'hC7);

        repeat (2) @(negedge clk);
        chk("re_we_overlap", overlap, 0);
        chk("final_qsize", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
